cpu_io_bridge: RTL
==================

Name: cpu_io_bridge

Overview:
- External-side peripheral for the CPU wrapper's I/O interface.
- Buffers bytes from an external valid/ready source into an RX FIFO and presents the head byte on the CPU input port.
- Raises the CPU interrupt line when input data is pending.
- Captures CPU output-port writes into a TX FIFO that drains to an external valid/ready sink.

Parameters:
- RX_DEPTH, 4, RX FIFO entries (power of two, >=2).
- TX_DEPTH, 4, TX FIFO entries (power of two, >=2).
- INT_CYCLES, 2, number of cycles int_sig is held high per interrupt (>=1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- ext_rx_data  in  8  byte offered by external source.
- ext_rx_valid  in  1  ext_rx_data valid.
- ext_rx_ready  out  1  RX FIFO can accept; equals !rx_full.
- i_port  out  8  to CPU I_Port; RX head byte, 8'h00 when RX empty.
- cpu_in_rd  in  1  CPU consumed i_port this cycle; pops RX head.
- int_sig  out  1  to CPU interrupt input.
- o_port  in  8  from CPU O_Port.
- cpu_out_wr  in  1  CPU IO write strobe; o_port valid.
- ext_tx_data  out  8  TX head byte.
- ext_tx_valid  out  1  equals !tx_empty.
- ext_tx_ready  in  1  external sink accepts.
- tx_drop  out  1  sticky; a CPU write was lost because TX was full.

Behaviour:
- Reset (async, active-high):
  - Both FIFOs empty; pointers and counts 0.
  - FSM in IDLE; INT_CYCLES counter 0.
  - Outputs: i_port=0, int_sig=0, ext_rx_ready=1, ext_tx_valid=0, ext_tx_data=0, tx_drop=0.
  - Reset mid-operation discards all buffered data immediately.
- FIFO pointers and counts:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - full = (count==DEPTH); empty = (count==0).
- RX push:
  - Occurs on ext_rx_valid & ext_rx_ready.
  - ext_rx_ready is !rx_full only; it does not depend on a same-cycle pop (no pop-through).
- RX pop and i_port:
  - Pop occurs on cpu_in_rd & !rx_empty.
  - cpu_in_rd while empty is ignored with no state change.
  - i_port is combinational from the head entry.
  - A byte pushed at edge N appears on i_port in the cycle after edge N.
- RX simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- TX push:
  - Occurs on cpu_out_wr.
  - If tx_full and no same-cycle pop: the byte is dropped and tx_drop is set; tx_drop stays 1 until rst.
  - If tx_full with a same-cycle pop (ext_tx_valid & ext_tx_ready): the push is accepted.
- TX pop: occurs on ext_tx_valid & ext_tx_ready; ext_tx_data is combinational from the head entry.
- Interrupt FSM (registered int_sig):
  - IDLE: int_sig=0. If !rx_empty, go to PULSE and load cnt=INT_CYCLES-1.
  - PULSE: int_sig=1.
    - If cnt==0, go to WAIT; otherwise decrement cnt.
    - An RX pop during PULSE aborts: go to IDLE, int_sig=0 next cycle.
  - WAIT: int_sig=0. On an RX pop, go to IDLE.
    - If bytes remain, IDLE re-enters PULSE on the next edge, giving at least one low cycle between pulses.
  - cpu_in_rd on empty RX does not cause a WAIT exit.
- State encoding is 2 bits; the unused code returns to IDLE.

Optional Feature:
- Macro IO_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - While loopback=1: the TX head is pushed into RX whenever !tx_empty & !rx_full, popping TX the same cycle.
  - ext_tx_valid and ext_rx_ready are forced 0; ext_rx_data is ignored.
  - Interrupt FSM behaviour is unchanged.
- When undefined: the port is absent and only the external paths exist.

Decomposition:
- Package cpu_io_pkg:
  - DATA_W=8.
  - Interrupt FSM state localparams IDLE=2'd0, PULSE=2'd1, WAIT=2'd2.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-high rst.
  - Instantiated twice (RX, TX).
- The FSM and drop flag live in the top level.

Test Plan:
- Reset then push 8'hA5:
  - ext_rx_ready=1 before the push.
  - i_port=8'hA5 one cycle after acceptance.
  - int_sig high exactly 2 cycles, then 0.
  - cpu_in_rd gives i_port=0 and FSM in IDLE.
- Push 4 bytes 01..04 with no reads: ext_rx_ready=0 after the 4th; a 5th byte held on valid is not accepted; reads return 01,02,03,04 in order.
- Three bytes buffered: after each cpu_in_rd, int_sig re-pulses after at least one low cycle; no pulse after the last byte is read.
- cpu_out_wr with 10,20,30,40,50 while ext_tx_ready=0: 50 is dropped and tx_drop=1. Then ext_tx_ready=1 drains 10,20,30,40 and tx_drop stays 1.
- TX full, cpu_out_wr=60 in the same cycle as a TX pop: 60 is accepted and tx_drop stays 0.
- rst asserted mid-PULSE with 2 RX bytes: int_sig=0, i_port=0 and ext_tx_valid=0 immediately (async); the FSM resumes in IDLE.

Source files
------------

// File: rtl/cpu_io_bridge_pkg.sv
// Shared definitions for the CPU I/O bridge: data width and interrupt FSM states.
package cpu_io_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } int_state_e;

endpackage

// File: rtl/cpu_io_bridge_if.sv
// Bus bundle between the CPU/external side (master) and the bridge (slave).
interface cpu_io_bridge_if;
  import cpu_io_pkg::*;

  logic [DATA_W-1:0] ext_rx_data;
  logic              ext_rx_valid;
  logic              ext_rx_ready;
  logic [DATA_W-1:0] i_port;
  logic              cpu_in_rd;
  logic              int_sig;
  logic [DATA_W-1:0] o_port;
  logic              cpu_out_wr;
  logic [DATA_W-1:0] ext_tx_data;
  logic              ext_tx_valid;
  logic              ext_tx_ready;
  logic              tx_drop;

  modport master (
    output ext_rx_data, ext_rx_valid, cpu_in_rd, o_port, cpu_out_wr, ext_tx_ready,
    input  ext_rx_ready, i_port, int_sig, ext_tx_data, ext_tx_valid, tx_drop
  );

  modport slave (
    input  ext_rx_data, ext_rx_valid, cpu_in_rd, o_port, cpu_out_wr, ext_tx_ready,
    output ext_rx_ready, i_port, int_sig, ext_tx_data, ext_tx_valid, tx_drop
  );

endinterface

// File: rtl/cpu_io_bridge_sync_fifo.sv
// Single-clock FIFO with a combinational head output (zero when empty).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == {(AW+1){1'b0}});
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_io_bridge.sv
// CPU I/O bridge: RX FIFO feeding i_port with interrupt pulses, TX FIFO draining o_port writes.
// Optional internal TX->RX path enabled by defining IO_LOOPBACK_EN.
module cpu_io_bridge
  import cpu_io_pkg::*;
#(
  parameter int RX_DEPTH   = 4,
  parameter int TX_DEPTH   = 4,
  parameter int INT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef IO_LOOPBACK_EN
  input  logic loopback,
`endif
  cpu_io_bridge_if.slave io
);

  localparam int CNT_W = $clog2(INT_CYCLES + 1);

  logic [DATA_W-1:0] rx_din;
  logic [DATA_W-1:0] rx_dout;
  logic [DATA_W-1:0] tx_dout;
  logic              rx_push;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_ready;
  logic              tx_valid;
  logic              drop_d;
  logic              drop_q;
  int_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              int_q;

  // Route RX source and TX sink either to the external ports or to each other.
  always_comb begin
    rx_push  = 1'b0;
    rx_din   = {DATA_W{1'b0}};
    tx_pop   = 1'b0;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
`ifdef IO_LOOPBACK_EN
    if (loopback) begin
      rx_push = ~tx_empty & ~rx_full;
      rx_din  = tx_dout;
      tx_pop  = ~tx_empty & ~rx_full;
    end else begin
      rx_ready = ~rx_full;
      tx_valid = ~tx_empty;
      rx_push  = io.ext_rx_valid & rx_ready;
      rx_din   = io.ext_rx_data;
      tx_pop   = tx_valid & io.ext_tx_ready;
    end
`else
    rx_ready = ~rx_full;
    tx_valid = ~tx_empty;
    rx_push  = io.ext_rx_valid & rx_ready;
    rx_din   = io.ext_rx_data;
    tx_pop   = tx_valid & io.ext_tx_ready;
`endif
  end

  assign rx_pop = io.cpu_in_rd & ~rx_empty;
  assign drop_d = drop_q | (io.cpu_out_wr & tx_full & ~tx_pop);

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_din),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (io.cpu_out_wr),
    .pop   (tx_pop),
    .din   (io.o_port),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Sticky record of a CPU write lost to a full TX FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  // Interrupt FSM: a read during the pulse aborts it; WAIT holds off until the CPU reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      int_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx_empty) begin
            state_q <= PULSE;
            cnt_q   <= CNT_W'(INT_CYCLES - 1);
            int_q   <= 1'b1;
          end else begin
            int_q   <= 1'b0;
          end
        end
        PULSE: begin
          if (rx_pop) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
          end else if (cnt_q == {CNT_W{1'b0}}) begin
            state_q <= WAIT;
            int_q   <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            int_q   <= 1'b1;
          end
        end
        WAIT: begin
          int_q <= 1'b0;
          if (rx_pop) begin
            state_q <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= {CNT_W{1'b0}};
          int_q   <= 1'b0;
        end
      endcase
    end
  end

  assign io.ext_rx_ready = rx_ready;
  assign io.ext_tx_valid = tx_valid;
  assign io.ext_tx_data  = tx_dout;
  assign io.i_port       = rx_dout;
  assign io.int_sig      = int_q;
  assign io.tx_drop      = drop_q;

endmodule
